bip_datapath: RTL and testbench
===============================

Name: bip_datapath

Overview:
- Execution end of the BIP processor.
- Consumes the decoded control word and operand issued each instruction by the control unit (which owns PC/program address and opcode decode).
- Holds the accumulator, performs add/sub, and owns the synchronous data RAM.
- Handshakes with the control unit so the 2-cycle memory-read instructions (LD, ADD, SUB) stall the PC correctly.

Parameters:
- DATA_WIDTH, 16, accumulator/RAM word width.
- OPERAND_LENGTH, 11, operand field width; also the data RAM address width.
- RAM_DEPTH, 2048, data RAM words (must equal 2**OPERAND_LENGTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ctrl_valid  in  1  control word/operand valid this cycle.
- ctrl_ready  out  1  datapath can accept a control word.
- operand  in  OPERAND_LENGTH  immediate value or RAM address.
- sel_a  in  2  acc source: 0=RAM data, 1=sign-extended operand, 2=ALU result, 3=reserved.
- sel_b  in  1  ALU B source: 0=RAM data, 1=sign-extended operand.
- alu_op  in  1  0=add, 1=sub (acc - B).
- wr_acc  in  1  update acc on retirement.
- wr_ram  in  1  write acc to RAM[operand].
- acc  out  DATA_WIDTH  accumulator register.
- zero  out  1  acc == 0.
- done  out  1  one-cycle pulse, instruction retired.

Behaviour:
- Reset (async, reset=0):
  - acc=0, ctrl_ready=1, done=0, state=IDLE.
  - RAM contents are not cleared.
  - Takes effect immediately and overrides any in-flight instruction.
- Accept condition: a word is accepted on a rising edge where ctrl_valid && ctrl_ready.
- Memory-read instruction: wr_acc=1 and (sel_a==0 or (sel_a==2 and sel_b==0)). All other words are single-cycle.
- FSM states IDLE and WAIT.
  - IDLE: ctrl_ready=1.
  - IDLE, single-cycle word accepted:
    - at the accept edge, acc <= source (if wr_acc && sel_a!=3);
    - RAM[operand] <= acc (old value) if wr_ram;
    - done=1 for the following cycle; stay IDLE.
  - IDLE, memory-read word accepted:
    - register sel_a/sel_b/alu_op/wr_acc and the sign-extended operand;
    - issue RAM read at operand;
    - go to WAIT.
  - WAIT: ctrl_ready=0, so the control unit must hold its PC.
    - Next edge: acc <= RAM data (sel_a==0) or acc ± RAM data (sel_a==2);
    - done=1 the following cycle; return to IDLE.
- Throughput: single-cycle words 1/clk; memory-read words 1 per 2 clk. Latency from accept edge to acc updated: 1 edge or 2 edges respectively.
- Immediate path: operand sign-extended from OPERAND_LENGTH to DATA_WIDTH.
- Arithmetic: modulo 2**DATA_WIDTH, no flags except zero. zero is combinational from the acc register.
- Conflicting controls:
  - wr_ram together with a memory-read word is illegal. The write happens at the accept edge and the read returns the pre-write data (read-first RAM).
  - sel_a==3 with wr_acc: acc unchanged, done still pulses.
- Store then load same address on consecutive accepts: the load returns the stored value (write and read on distinct edges).
- ctrl_valid=0: no state change, done=0.
- Reset asserted during WAIT: pending load discarded; after release, IDLE with acc=0.

Decomposition:
- Shared package bip_pkg holds:
  - DATA_WIDTH and OPERAND_LENGTH constants;
  - SEL_A_RAM/SEL_A_IMM/SEL_A_ALU encodings;
  - SEL_B_RAM/SEL_B_IMM encodings;
  - ALU_ADD/ALU_SUB encodings;
  - FSM state encodings.
- Sub-module bip_data_ram: single-port, synchronous read-first, one write port. It is shared with the future memory-mapped I/O work.

Test Plan:
- Reset low for 2 cycles, then high → acc=0, zero=1, ctrl_ready=1, done=0.
- LDI 5 (sel_a=1, wr_acc=1, operand=5), then ADDI -3 (operand=0x7FD, sel_a=2, sel_b=1, alu_op=0) → acc=5 after edge 1 and 2 after edge 2; done high each following cycle; ctrl_ready stays 1.
- STO 10 with acc=2, then LD 10 → ctrl_ready=0 for exactly one cycle during LD; acc=2 two edges after LD accept.
- acc=0x7FFF, then ADDI 1 → acc=0x8000 (wrap); then SUBI from acc=0 → acc=0xFFFF, zero=0.
- SUB from RAM, then reset pulse in WAIT → acc=0, ctrl_ready=1, no done pulse; the following LDI 7 gives acc=7.
- Back-to-back ADD mem[3]=4 from acc=1 with ctrl_valid held high → second word not accepted until ctrl_ready returns; acc=5 then 9.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared constants and encodings for the BIP processor datapath and its control unit.
package bip_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int OPERAND_LENGTH = 11;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic [1:0] SEL_A_RSV = 2'd3;

  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/bip_data_ram.sv
// Single-port synchronous data RAM, read-first: a write and a read on the same edge return the old word.
module bip_data_ram
  import bip_pkg::*;
#(
  parameter int WORD_WIDTH = DATA_WIDTH,
  parameter int ADDR_WIDTH = OPERAND_LENGTH,
  parameter int DEPTH      = 2 ** OPERAND_LENGTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, add/sub ALU and data RAM, with a two-state
// handshake that stalls the control unit while a memory-read instruction completes.
module bip_datapath #(
  parameter int DATA_WIDTH     = bip_pkg::DATA_WIDTH,
  parameter int OPERAND_LENGTH = bip_pkg::OPERAND_LENGTH,
  parameter int RAM_DEPTH      = 2 ** bip_pkg::OPERAND_LENGTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ctrl_valid,
  output logic                      ctrl_ready,
  input  logic [OPERAND_LENGTH-1:0] operand,
  input  logic [1:0]                sel_a,
  input  logic                      sel_b,
  input  logic                      alu_op,
  input  logic                      wr_acc,
  input  logic                      wr_ram,
  output logic [DATA_WIDTH-1:0]     acc,
  output logic                      zero,
  output logic                      done
);
  import bip_pkg::*;

  function automatic logic signed [DATA_WIDTH-1:0] sext(input logic [OPERAND_LENGTH-1:0] v);
    return DATA_WIDTH'(signed'(v));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] alu(
    input logic                         op,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (op == ALU_SUB) ? a - b : a + b;
  endfunction

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] acc_p1;
  logic signed [DATA_WIDTH-1:0] rdata_p1;
  logic                         ld_alu_p1;
  logic                         alu_op_p1;

  logic                         accept_p0;
  logic                         mem_rd_p0;
  logic signed [DATA_WIDTH-1:0] imm_p0;
  logic signed [DATA_WIDTH-1:0] b_p0;
  logic signed [DATA_WIDTH-1:0] src_p0;

  // Stage 0: decode the offered word and form the single-cycle result.
  assign accept_p0 = ctrl_valid && ctrl_ready;
  assign mem_rd_p0 = wr_acc && ((sel_a == SEL_A_RAM) ||
                                ((sel_a == SEL_A_ALU) && (sel_b == SEL_B_RAM)));

  always_comb begin
    imm_p0 = sext(operand);
    b_p0   = (sel_b == SEL_B_IMM) ? imm_p0 : rdata_p1;
    src_p0 = acc_p1;
    case (sel_a)
      SEL_A_IMM: src_p0 = imm_p0;
      SEL_A_ALU: src_p0 = alu(alu_op, acc_p1, b_p0);
      default:   src_p0 = acc_p1;
    endcase
  end

  // The RAM is addressed straight from the operand so the read issues at the accept edge.
  bip_data_ram #(
    .WORD_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(OPERAND_LENGTH),
    .DEPTH     (RAM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (accept_p0 && wr_ram),
    .addr (operand),
    .wdata(acc_p1),
    .rdata(rdata_p1)
  );

  // Stage 1: retire single-cycle words at once, memory-read words one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ctrl_ready <= 1'b1;
      done       <= 1'b0;
      acc_p1     <= '0;
      ld_alu_p1  <= 1'b0;
      alu_op_p1  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_p0) begin
            if (mem_rd_p0) begin
              state      <= ST_WAIT;
              ctrl_ready <= 1'b0;
              ld_alu_p1  <= (sel_a == SEL_A_ALU);
              alu_op_p1  <= alu_op;
            end else begin
              done <= 1'b1;
              if (wr_acc && (sel_a != SEL_A_RSV)) acc_p1 <= src_p0;
            end
          end
        end
        ST_WAIT: begin
          acc_p1     <= ld_alu_p1 ? alu(alu_op_p1, acc_p1, rdata_p1) : rdata_p1;
          done       <= 1'b1;
          ctrl_ready <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign acc  = acc_p1;
  assign zero = (acc_p1 == '0);

endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath: instruction-level reference model checked every cycle, plus literal checkpoints.
module tb_bip_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready;
  logic [10:0] operand = '0;
  logic [1:0]  sel_a = '0;
  logic        sel_b = 1'b0;
  logic        alu_op = 1'b0;
  logic        wr_acc = 1'b0;
  logic        wr_ram = 1'b0;
  logic [15:0] acc;
  logic        zero;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  bip_datapath #(
    .DATA_WIDTH    (16),
    .OPERAND_LENGTH(11),
    .RAM_DEPTH     (2048)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .operand   (operand),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .alu_op    (alu_op),
    .wr_acc    (wr_acc),
    .wr_ram    (wr_ram),
    .acc       (acc),
    .zero      (zero),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one instruction at a time, memory reads take an extra cycle.
  logic [15:0] m_acc = '0;
  logic [15:0] m_mem [2048];
  logic [15:0] m_pend = '0;
  int          m_kind = 0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic [15:0] imm;
    logic [15:0] nacc;
    if (!reset) begin
      m_acc  <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      case (m_kind)
        0:       m_acc <= m_pend;
        1:       m_acc <= m_acc + m_pend;
        default: m_acc <= m_acc - m_pend;
      endcase
      m_busy <= 1'b0;
      m_done <= 1'b1;
    end else if (ctrl_valid) begin
      imm  = {{5{operand[10]}}, operand};
      nacc = m_acc;
      if (wr_acc && (sel_a == 2'd0 || (sel_a == 2'd2 && sel_b == 1'b0))) begin
        m_pend <= m_mem[operand];
        m_kind <= (sel_a == 2'd0) ? 0 : (alu_op ? 2 : 1);
        m_busy <= 1'b1;
        m_done <= 1'b0;
      end else begin
        if (wr_acc && sel_a == 2'd1) nacc = imm;
        if (wr_acc && sel_a == 2'd2) nacc = alu_op ? m_acc - imm : m_acc + imm;
        m_acc  <= nacc;
        m_done <= 1'b1;
      end
      if (wr_ram) m_mem[operand] <= m_acc;
    end else begin
      m_done <= 1'b0;
    end
  end

  initial begin
    #3;
    forever begin
      @(posedge clk);
      #3;
      chk("model_acc", acc, m_acc);
      chk("model_zero", zero, (m_acc == 16'h0));
      chk("model_ready", ctrl_ready, !m_busy);
      chk("model_done", done, m_done);
    end
  end

  // Offer a word at a negedge and hold it until an edge sees ctrl_ready high.
  task automatic send(input logic [10:0] opnd, input logic [1:0] sa, input logic sb,
                      input logic ao, input logic wa, input logic wrr);
    int  waited = 0;
    bit  took;
    ctrl_valid = 1'b1;
    operand    = opnd;
    sel_a      = sa;
    sel_b      = sb;
    alu_op     = ao;
    wr_acc     = wa;
    wr_ram     = wrr;
    forever begin
      took = ctrl_ready;
      @(negedge clk);
      if (took) break;
      waited++;
      if (waited > 8) begin
        chk("accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    ctrl_valid = 1'b0;
    wr_acc     = 1'b0;
    wr_ram     = 1'b0;
  endtask

  task automatic ldi(input logic [10:0] v);  send(v, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic addi(input logic [10:0] v); send(v, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic subi(input logic [10:0] v); send(v, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0); endtask
  task automatic sto(input logic [10:0] a);  send(a, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic ld(input logic [10:0] a);   send(a, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic add(input logic [10:0] a);  send(a, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic sub(input logic [10:0] a);  send(a, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0); endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_acc", acc, 16'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_ready", ctrl_ready, 1'b1);
    chk("rst_done", done, 1'b0);

    ldi(11'd5);
    chk("ldi5_acc", acc, 16'h0005);
    chk("ldi5_done", done, 1'b1);
    addi(11'h7FD);
    chk("addi_m3_acc", acc, 16'h0002);
    chk("addi_m3_ready", ctrl_ready, 1'b1);
    @(negedge clk);
    chk("idle_done", done, 1'b0);

    sto(11'd10);
    chk("sto_done", done, 1'b1);
    ld(11'd10);
    chk("ld_stall", ctrl_ready, 1'b0);
    chk("ld_nodone", done, 1'b0);
    @(negedge clk);
    chk("ld_acc", acc, 16'h0002);
    chk("ld_ready_back", ctrl_ready, 1'b1);
    chk("ld_done", done, 1'b1);

    ldi(11'h400);
    chk("ldi_m1024", acc, 16'hFC00);
    for (int i = 0; i < 5; i++) begin
      sto(11'd20);
      add(11'd20);
    end
    @(negedge clk);
    chk("double_acc", acc, 16'h8000);
    subi(11'd1);
    chk("sub_wrap", acc, 16'h7FFF);
    addi(11'd1);
    chk("add_wrap", acc, 16'h8000);
    ldi(11'd0);
    chk("ldi0_zero", zero, 1'b1);
    subi(11'd1);
    chk("subi_ffff", acc, 16'hFFFF);
    chk("subi_nz", zero, 1'b0);

    send(11'd9, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rsv_acc", acc, 16'hFFFF);
    chk("rsv_done", done, 1'b1);

    sto(11'd30);
    ldi(11'd5);
    sub(11'd30);
    chk("sub_wait", ctrl_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rstwait_acc", acc, 16'h0);
    chk("rstwait_ready", ctrl_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstwait_nodone", done, 1'b0);
    chk("rstwait_acc2", acc, 16'h0);
    ldi(11'd7);
    chk("ldi7_acc", acc, 16'h0007);

    ldi(11'd4);
    sto(11'd3);
    ldi(11'd1);
    add(11'd3);
    add(11'd3);
    chk("b2b_first", acc, 16'h0005);
    chk("b2b_stall", ctrl_ready, 1'b0);
    @(negedge clk);
    chk("b2b_second", acc, 16'h0009);
    chk("b2b_done", done, 1'b1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
